// File: rtl/mem_stage.sv
// MIPS memory-access stage: little-endian byte/half/word data memory, branch
// resolution, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_RegWrite,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemToReg,
  input  logic        in_Branch,
  input  logic        in_zero,
  input  logic [1:0]  in_load_mode,
  input  logic [4:0]  in_writebackDestination,
  input  logic [31:0] in_aluResult,
  input  logic [31:0] in_rt,
  input  logic [31:0] in_pc,
  output logic        PCSrc_out,
  output logic [31:0] branch_target_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [4:0]  writebackDestination_out,
  output logic [31:0] aluResult_out,
  output logic [31:0] mem_read_data_out,
  output logic        addr_error_out
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  localparam logic [1:0] MODE_WORD  = 2'd0;
  localparam logic [1:0] MODE_HALF  = 2'd1;
  localparam logic [1:0] MODE_BYTES = 2'd2;
  localparam logic [1:0] MODE_BYTEU = 2'd3;

  logic [31:0] mem [DEPTH];

  logic [MEM_ADDR_BITS-1:0] word_idx;
  logic [1:0]               lane;
  logic [31:0]              rd_word;
  logic [15:0]              rd_half;
  logic [7:0]               rd_byte;
  logic [31:0]              load_data;
  logic [31:0]              wr_data;
  logic [3:0]               byte_en;
  logic                     misaligned;
  logic                     addr_error;
  logic                     mem_we;

  assign PCSrc_out         = in_Branch & in_zero;
  assign branch_target_out = in_pc;

  // Upper address bits are ignored, so addresses alias modulo the memory size.
  assign word_idx = in_aluResult[MEM_ADDR_BITS+1:2];
  assign lane     = in_aluResult[1:0];
  assign rd_word  = mem[word_idx];

  always_comb begin
    misaligned = 1'b0;
    unique case (in_load_mode)
      MODE_WORD:  misaligned = (lane != 2'b00);
      MODE_HALF:  misaligned = lane[0];
      MODE_BYTES,
      MODE_BYTEU: misaligned = 1'b0;
      default:    misaligned = 1'b0;
    endcase
  end

  assign addr_error = (in_MemRead | in_MemWrite) & misaligned;
  // Stores are held off while reset is asserted so a reset edge never commits.
  assign mem_we     = in_MemWrite & ~misaligned & rst_n;

  always_comb begin
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte = rd_word[7:0];
    unique case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_data = rd_word;
    unique case (in_load_mode)
      MODE_WORD:  load_data = rd_word;
      MODE_HALF:  load_data = {{16{rd_half[15]}}, rd_half};
      MODE_BYTES: load_data = {{24{rd_byte[7]}}, rd_byte};
      MODE_BYTEU: load_data = {24'd0, rd_byte};
      default:    load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes; byte enables pick the lanes written.
  always_comb begin
    byte_en = 4'b1111;
    wr_data = in_rt;
    unique case (in_load_mode)
      MODE_WORD: begin
        byte_en = 4'b1111;
        wr_data = in_rt;
      end
      MODE_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{in_rt[15:0]}};
      end
      MODE_BYTES,
      MODE_BYTEU: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{in_rt[7:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = in_rt;
      end
    endcase
  end

  // No reset on the array: contents survive reset and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_out             <= 1'b0;
      MemToReg_out             <= 1'b0;
      writebackDestination_out <= 5'd0;
      aluResult_out            <= 32'd0;
      mem_read_data_out        <= 32'd0;
      addr_error_out           <= 1'b0;
    end else begin
      RegWrite_out             <= in_RegWrite & ~addr_error;
      MemToReg_out             <= in_MemToReg;
      writebackDestination_out <= in_writebackDestination;
      aluResult_out            <= in_aluResult;
      mem_read_data_out        <= (in_MemRead & ~addr_error) ? load_data : 32'd0;
      addr_error_out           <= addr_error;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset/branch sequences, and
// random traffic checked against a byte-array reference memory.
module tb_mem_stage;

  localparam int AB = 8;
  localparam int NBYTES = 4 << AB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg;
  logic        in_Branch, in_zero;
  logic [1:0]  in_load_mode;
  logic [4:0]  in_writebackDestination;
  logic [31:0] in_aluResult, in_rt, in_pc;
  logic        PCSrc_out;
  logic [31:0] branch_target_out;
  logic        RegWrite_out, MemToReg_out, addr_error_out;
  logic [4:0]  writebackDestination_out;
  logic [31:0] aluResult_out, mem_read_data_out;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] ref_mem [NBYTES];

  logic        exp_rw, exp_mtr, exp_err;
  logic [4:0]  exp_dest;
  logic [31:0] exp_alu, exp_data;

  always #5 clk = ~clk;

  mem_stage #(.MEM_ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_RegWrite(in_RegWrite), .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead),
    .in_MemToReg(in_MemToReg), .in_Branch(in_Branch), .in_zero(in_zero),
    .in_load_mode(in_load_mode), .in_writebackDestination(in_writebackDestination),
    .in_aluResult(in_aluResult), .in_rt(in_rt), .in_pc(in_pc),
    .PCSrc_out(PCSrc_out), .branch_target_out(branch_target_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .writebackDestination_out(writebackDestination_out),
    .aluResult_out(aluResult_out), .mem_read_data_out(mem_read_data_out),
    .addr_error_out(addr_error_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " RegWrite"}, 32'(RegWrite_out), 32'd0);
    chk({tag, " MemToReg"}, 32'(MemToReg_out), 32'd0);
    chk({tag, " dest"}, 32'(writebackDestination_out), 32'd0);
    chk({tag, " alu"}, aluResult_out, 32'd0);
    chk({tag, " rdata"}, mem_read_data_out, 32'd0);
    chk({tag, " err"}, 32'(addr_error_out), 32'd0);
  endtask

  // Reference: an access of `size` bytes at byte address a (mod memory size);
  // reads happen before writes, matching read-first semantics.
  task automatic model(input logic we, input logic re, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] rt, input logic rw,
                       input logic mtr, input logic [4:0] dest);
    int unsigned size, base;
    logic [31:0] val;
    logic mis;
    size = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 2 : 1;
    base = a % NBYTES;
    mis  = (we || re) && ((a % size) != 0);
    val  = 32'd0;
    if (re && !mis) begin
      for (int k = 0; k < int'(size); k++) val = val | (32'(ref_mem[(base + k) % NBYTES]) << (8 * k));
      if (mode == 2'd1 && val >= 32'h8000) val = val | 32'hFFFF0000;
      if (mode == 2'd2 && val >= 32'h80) val = val | 32'hFFFFFF00;
    end
    if (we && !mis) begin
      for (int k = 0; k < int'(size); k++) ref_mem[(base + k) % NBYTES] = 8'(rt >> (8 * k));
    end
    exp_data = val;
    exp_err  = mis;
    exp_rw   = rw & ~mis;
    exp_mtr  = mtr;
    exp_dest = dest;
    exp_alu  = a;
  endtask

  task automatic apply(input logic we, input logic re, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] rt, input logic rw,
                       input logic mtr, input logic [4:0] dest);
    model(we, re, mode, a, rt, rw, mtr, dest);
    in_MemWrite = we; in_MemRead = re; in_load_mode = mode;
    in_aluResult = a; in_rt = rt; in_RegWrite = rw; in_MemToReg = mtr;
    in_writebackDestination = dest;
    @(posedge clk); #1;
    chk("model rdata", mem_read_data_out, exp_data);
    chk("model err", 32'(addr_error_out), 32'(exp_err));
    chk("model RegWrite", 32'(RegWrite_out), 32'(exp_rw));
    chk("model MemToReg", 32'(MemToReg_out), 32'(exp_mtr));
    chk("model dest", 32'(writebackDestination_out), 32'(exp_dest));
    chk("model alu", aluResult_out, exp_alu);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        rw;
    logic [31:0] x_data;
    logic        x_err;
    logic        x_rw;
  } vec_t;

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h10,  32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h10,  32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h13,  32'h0,        1'b1, 32'h00000012, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'h11,  32'h80,       1'b0, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 32'h11,  32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 32'h11,  32'h0,        1'b1, 32'h00000080, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h12,  32'h0,        1'b1, 32'h00001234, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h10,  32'h0,        1'b1, 32'h12348078, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 32'h20,  32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 32'h20,  32'hAAAA5555, 1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 32'h20,  32'h0,        1'b1, 32'hAAAA5555, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h22,  32'h0BADBEEF, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 32'h20,  32'h0,        1'b1, 32'hAAAA5555, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'd1, 32'h21,  32'h0,        1'b1, 32'h0,        1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 32'h400, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd0, 32'h0,   32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 32'h22,  32'h0,        1'b1, 32'h0,        1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 2'd3, 32'h402, 32'h0,        1'b1, 32'h000000FE, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 2'd1, 32'h403, 32'h1111,     1'b1, 32'h0,        1'b1, 1'b0};
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    in_RegWrite = 1'b0; in_MemWrite = 1'b0; in_MemRead = 1'b0; in_MemToReg = 1'b0;
    in_Branch = 1'b0; in_zero = 1'b0; in_load_mode = 2'd0;
    in_writebackDestination = 5'd0; in_aluResult = 32'd0; in_rt = 32'd0; in_pc = 32'd0;
    #1;
    chk_all_zero("power-up reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < (1 << AB); w++)
      apply(1'b1, 1'b0, 2'd0, 32'(w * 4), $urandom, 1'b0, 1'b0, 5'd0);

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].we, vecs[i].re, vecs[i].mode, vecs[i].addr, vecs[i].rt,
            vecs[i].rw, 1'b1, 5'(i));
      chk($sformatf("vec%0d rdata", i), mem_read_data_out, vecs[i].x_data);
      chk($sformatf("vec%0d err", i), 32'(addr_error_out), 32'(vecs[i].x_err));
      chk($sformatf("vec%0d RegWrite", i), 32'(RegWrite_out), 32'(vecs[i].x_rw));
      chk($sformatf("vec%0d alu", i), aluResult_out, vecs[i].addr);
    end

    // Branch outputs are purely combinational.
    in_Branch = 1'b1; in_zero = 1'b1; in_pc = 32'h400; #1;
    chk("branch taken", 32'(PCSrc_out), 32'd1);
    chk("branch target", branch_target_out, 32'h400);
    in_zero = 1'b0; #1;
    chk("branch not taken", 32'(PCSrc_out), 32'd0);
    in_Branch = 1'b0; in_zero = 1'b1; #1;
    chk("no branch", 32'(PCSrc_out), 32'd0);

    // Mid-cycle async reset with a store pending: outputs clear, store dropped.
    apply(1'b0, 1'b0, 2'd0, 32'h55, 32'h0, 1'b1, 1'b1, 5'd7);
    in_MemWrite = 1'b1; in_MemRead = 1'b1; in_aluResult = 32'h30; in_rt = 32'hDEADBEEF;
    #2; rst_n = 1'b0; #1;
    chk_all_zero("async reset");
    in_Branch = 1'b1; in_zero = 1'b1; in_pc = 32'h1234; #1;
    chk("branch in reset", 32'(PCSrc_out), 32'd1);
    chk("target in reset", branch_target_out, 32'h1234);
    @(posedge clk); #1;
    chk_all_zero("held reset");
    @(negedge clk); rst_n = 1'b1; #1;
    chk_all_zero("after release");
    in_Branch = 1'b0;
    apply(1'b0, 1'b1, 2'd0, 32'h30, 32'h0, 1'b1, 1'b0, 5'd3);

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      in_Branch = 1'($urandom); in_zero = 1'($urandom); in_pc = $urandom;
      #1;
      chk("rand PCSrc", 32'(PCSrc_out), 32'(in_Branch & in_zero));
      chk("rand target", branch_target_out, in_pc);
      apply(1'($urandom), 1'($urandom), 2'($urandom), a, $urandom,
            1'($urandom), 1'($urandom), 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline and the consumer of the execute stage's EX/MEM outputs. It performs byte/halfword/word loads and stores on an internal little-endian data memory, resolves the branch decision, and registers results into the MEM/WB pipeline register for write-back. Every write-back-facing output is registered with one-cycle latency; the branch outputs are combinational.

## Interface
- MEM_ADDR_BITS, 8, word-index width; memory holds 2^MEM_ADDR_BITS 32-bit words.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_RegWrite  in  1  write-back enable from EX.
- in_MemWrite  in  1  store request.
- in_MemRead  in  1  load request.
- in_MemToReg  in  1  write-back source select (1 = memory data).
- in_Branch  in  1  instruction is a conditional branch.
- in_zero  in  1  ALU zero flag from EX.
- in_load_mode  in  2  access size: 0 word, 1 half signed, 2 byte signed, 3 byte unsigned.
- in_writebackDestination  in  5  destination register number.
- in_aluResult  in  32  byte address for loads/stores; ALU result for write-back.
- in_rt  in  32  store data.
- in_pc  in  32  branch target from EX.
- PCSrc_out  out  1  combinational: in_Branch & in_zero.
- branch_target_out  out  32  combinational pass-through of in_pc.
- RegWrite_out  out  1  registered write-back enable.
- MemToReg_out  out  1  registered.
- writebackDestination_out  out  5  registered.
- aluResult_out  out  32  registered.
- mem_read_data_out  out  32  registered, extended load data.
- addr_error_out  out  1  registered misaligned-access flag.

## Operation
- Word index = in_aluResult[MEM_ADDR_BITS+1:2]; higher address bits ignored (aliasing wrap).
- Byte lane = in_aluResult[1:0]; lane 0 = bits [7:0] (little-endian).
- Alignment: mode 0 requires addr[1:0]=0; mode 1 requires addr[0]=0; modes 2/3 always aligned.
- Store (in_MemWrite=1, aligned): mode 0 writes full word; mode 1 writes in_rt[15:0] to halfword lane addr[1]; modes 2/3 write in_rt[7:0] to lane addr[1:0]; other bytes untouched.
- Load (in_MemRead=1, aligned): select lane, then mode 1/2 sign-extend, mode 3 zero-extend, mode 0 full word.
- in_MemRead=0: mem_read_data_out registers 0.
- Misaligned access (MemRead or MemWrite set and alignment violated): no memory write; addr_error_out=1 for that cycle's result; RegWrite_out forced 0; mem_read_data_out=0.
- Neither MemRead nor MemWrite: addr_error_out=0 regardless of address.
- MemRead and MemWrite both 1: write performed; read returns pre-write contents (read-first).
- Pass-through registered: in_RegWrite (unless error), in_MemToReg, in_writebackDestination, in_aluResult.
- PCSrc_out/branch_target_out do not depend on clk or rst_n.

## Timing
- All registered outputs update at the rising edge after inputs are presented: latency 1 cycle.
- Memory write commits at the same edge; a load in the following cycle sees the new data.
- Back-to-back accesses every cycle; no stalls, no handshake.
- rst_n low: RegWrite_out, MemToReg_out, addr_error_out = 0; writebackDestination_out, aluResult_out, mem_read_data_out = 0, immediately (asynchronous). Memory contents not cleared; stores blocked while rst_n low.
- rst_n released: first update at the next rising edge.
- Reset asserted mid-pipeline: in-flight result discarded; store presented in the same cycle does not commit.
- Memory contents undefined after power-up until written.

## Test plan
- Reset: drive in_RegWrite=1, aluResult=0x55, pulse rst_n low between edges -> all registered outputs drop to 0 at once; remain 0 until first edge after release.
- Word round trip: sw 0x12345678 at addr 0x10 (mode 0), next cycle lw 0x10 -> mem_read_data_out=0x12345678, RegWrite_out=in_RegWrite, aluResult_out=0x10.
- Byte/half extension: after above, lb mode 2 addr 0x13 -> 0x00000012; sb 0x80 at 0x11 then lb mode 2 addr 0x11 -> 0xFFFFFF80, mode 3 -> 0x00000080; lh mode 1 addr 0x12 -> 0x00001234; word at 0x10 reads 0x12348078.
- Simultaneous read/write: location 0x20 holds 0x12345678; MemRead=MemWrite=1, mode 0, in_rt=0xAAAA5555 -> mem_read_data_out=0x12345678; next lw 0x20 -> 0xAAAA5555.
- Misaligned: sw mode 0 addr 0x22, in_RegWrite=1 -> addr_error_out=1, RegWrite_out=0, word 0x20 unchanged; lh addr 0x21 -> addr_error_out=1, mem_read_data_out=0.
- Branch and wrap: in_Branch=1, in_zero=1, in_pc=0x400 -> PCSrc_out=1, branch_target_out=0x400 same cycle; in_zero=0 -> PCSrc_out=0; sw to addr 0x400 (MEM_ADDR_BITS=8) then lw addr 0x0 -> same data (alias).
